// File: rtl/ctrl_pkg.sv
// Shared constants for the control pipeline unit:
// opcodes, bundle field indices, widths, FSM states.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [6:0] FUNCT7_MUL = 7'b0000001;

  localparam int ALUOP_W_DEF = 2;

  localparam int B_IS_MUL    = 0;
  localparam int B_REG_WRITE = 1;
  localparam int B_ALU_SRC   = 2;
  localparam int B_MEM_WRITE = 3;
  localparam int B_ALU_OP_LO = 4;

  function automatic int b_alu_op_hi(int w);
    return B_ALU_OP_LO + w - 1;
  endfunction

  function automatic int b_mem_to_reg(int w);
    return B_ALU_OP_LO + w;
  endfunction

  function automatic int b_mem_read(int w);
    return B_ALU_OP_LO + w + 1;
  endfunction

  function automatic int b_branch(int w);
    return B_ALU_OP_LO + w + 2;
  endfunction

  function automatic int b_jal(int w);
    return B_ALU_OP_LO + w + 3;
  endfunction

  function automatic int b_jalr(int w);
    return B_ALU_OP_LO + w + 4;
  endfunction

  function automatic int ctrl_w(int w);
    return 10 + w - 1;
  endfunction

  localparam int CTRL_W = ctrl_w(ALUOP_W_DEF);

  localparam logic [CTRL_W-1:0] BUBBLE = '0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } mul_state_e;

endpackage

// File: rtl/ctrl_pipe_unit_if.sv
// Core-side bus of the control pipeline unit:
// ID instruction and flush in, stage bundles out.
interface ctrl_pipe_unit_if
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W    = 2,
  parameter int REG_ADDR_W = 5
) ();

  localparam int CW = ctrl_w(ALUOP_W);

  logic [31:0]           instr_i;
  logic                  flush_i;
  logic [CW-1:0]         ex_ctrl_o;
  logic [REG_ADDR_W-1:0] ex_rd_o;
  logic [CW-1:0]         mem_ctrl_o;
  logic [CW-1:0]         wb_ctrl_o;
  logic [REG_ADDR_W-1:0] wb_rd_o;
  logic                  stall_o;
  logic                  mul_busy_o;
  logic                  illegal_o;

  modport master (
    output instr_i,
    output flush_i,
    input  ex_ctrl_o,
    input  ex_rd_o,
    input  mem_ctrl_o,
    input  wb_ctrl_o,
    input  wb_rd_o,
    input  stall_o,
    input  mul_busy_o,
    input  illegal_o
  );

  modport slave (
    input  instr_i,
    input  flush_i,
    output ex_ctrl_o,
    output ex_rd_o,
    output mem_ctrl_o,
    output wb_ctrl_o,
    output wb_rd_o,
    output stall_o,
    output mul_busy_o,
    output illegal_o
  );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational ID decode: control bundle, register
// fields and which source registers the op reads.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W = 2
) (
  input  logic [31:0]                 instr,
  output logic [ctrl_w(ALUOP_W)-1:0] ctrl,
  output logic                        valid,
  output logic                        rs1_used,
  output logic                        rs2_used,
  output logic [4:0]                  rs1,
  output logic [4:0]                  rs2,
  output logic [4:0]                  rd
);

  localparam int B_AHI  = b_alu_op_hi(ALUOP_W);
  localparam int B_M2R  = b_mem_to_reg(ALUOP_W);
  localparam int B_MRD  = b_mem_read(ALUOP_W);
  localparam int B_BR   = b_branch(ALUOP_W);
  localparam int B_JAL  = b_jal(ALUOP_W);
  localparam int B_JALR = b_jalr(ALUOP_W);

  logic [6:0] op;
  logic [6:0] funct7;
  logic       unused_funct3;

  assign op     = instr[6:0];
  assign funct7 = instr[31:25];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign unused_funct3 = ^instr[14:12];

  // opcode to bundle; alu_op only on real ops
  always_comb begin
    ctrl     = '0;
    valid    = 1'b0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    unique case (1'b1)
      (op == OP_R): begin
        valid            = 1'b1;
        rs1_used         = 1'b1;
        rs2_used         = 1'b1;
        ctrl[B_REG_WRITE] = 1'b1;
        ctrl[B_IS_MUL]    = (funct7 == FUNCT7_MUL);
      end
      (op == OP_I): begin
        valid             = 1'b1;
        rs1_used          = 1'b1;
        ctrl[B_ALU_SRC]   = 1'b1;
        ctrl[B_REG_WRITE] = 1'b1;
      end
      (op == OP_LOAD): begin
        valid             = 1'b1;
        rs1_used          = 1'b1;
        ctrl[B_MRD]       = 1'b1;
        ctrl[B_M2R]       = 1'b1;
        ctrl[B_ALU_SRC]   = 1'b1;
        ctrl[B_REG_WRITE] = 1'b1;
      end
      (op == OP_STORE): begin
        valid           = 1'b1;
        rs1_used        = 1'b1;
        rs2_used        = 1'b1;
        ctrl[B_MEM_WRITE] = 1'b1;
        ctrl[B_ALU_SRC]   = 1'b1;
      end
      (op == OP_BRANCH): begin
        valid      = 1'b1;
        rs1_used   = 1'b1;
        rs2_used   = 1'b1;
        ctrl[B_BR] = 1'b1;
      end
      (op == OP_JAL): begin
        valid             = 1'b1;
        ctrl[B_JAL]       = 1'b1;
        ctrl[B_BR]        = 1'b1;
        ctrl[B_REG_WRITE] = 1'b1;
      end
      (op == OP_JALR): begin
        valid             = 1'b1;
        rs1_used          = 1'b1;
        ctrl[B_JALR]      = 1'b1;
        ctrl[B_BR]        = 1'b1;
        ctrl[B_REG_WRITE] = 1'b1;
      end
      default: ;
    endcase
    if (valid) begin
      ctrl[B_AHI:B_ALU_OP_LO] = op[ALUOP_W+2:3];
    end
  end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// Control pipeline: decode, ID/EX..MEM/WB control regs,
// load-use and multi-cycle MUL stalls.
// Optional sticky illegal-opcode flag: CTRL_ILLEGAL_TRAP_EN.
module ctrl_pipe_unit
  import ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int ALUOP_W    = 2,
  parameter int REG_ADDR_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  ctrl_pipe_unit_if.slave bus
);

  localparam int CW    = ctrl_w(ALUOP_W);
  localparam int B_MRD = b_mem_read(ALUOP_W);
  localparam int CNT_W = 4;
  localparam bit MUL_MC = (MUL_CYCLES > 1);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(MUL_MC ? MUL_CYCLES - 2 : 0);
  localparam logic [CW-1:0] BUB = '0;

  logic [CW-1:0]         dec_ctrl;
  logic                  dec_valid;
  logic                  rs1_used;
  logic                  rs2_used;
  logic [4:0]            rs1_f;
  logic [4:0]            rs2_f;
  logic [4:0]            rd_f;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic [REG_ADDR_W-1:0] rd;

  logic [CW-1:0]         ex_ctrl;
  logic [CW-1:0]         mem_ctrl;
  logic [CW-1:0]         wb_ctrl;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [REG_ADDR_W-1:0] wb_rd;

  mul_state_e            state;
  logic [CNT_W-1:0]      cnt;

  logic mul_start;
  logic mul_hold;
  logic load_use;
  logic stall;

  ctrl_decode #(
    .ALUOP_W (ALUOP_W)
  ) u_dec (
    .instr    (bus.instr_i),
    .ctrl     (dec_ctrl),
    .valid    (dec_valid),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used),
    .rs1      (rs1_f),
    .rs2      (rs2_f),
    .rd       (rd_f)
  );

  assign rs1 = REG_ADDR_W'(rs1_f);
  assign rs2 = REG_ADDR_W'(rs2_f);
  assign rd  = REG_ADDR_W'(rd_f);

  // The MUL holds EX from its first cycle; the last
  // BUSY cycle (cnt==0) lets it and ID advance.
  assign mul_start = MUL_MC && (state == S_IDLE)
                   && ex_ctrl[B_IS_MUL];
  assign mul_hold  = mul_start
                   || ((state == S_BUSY) && (cnt != '0));

  assign load_use = ex_ctrl[B_MRD] && (ex_rd != '0)
                  && ((rs1_used && (rs1 == ex_rd))
                   || (rs2_used && (rs2 == ex_rd)));

  assign stall = mul_hold || load_use;

  // MUL sequencer: count remaining EX cycles
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (mul_start) begin
            state <= S_BUSY;
            cnt   <= CNT_LOAD;
          end
        end
        S_BUSY: begin
          if (cnt == '0) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      endcase
    end
  end

  // Stage registers: MUL hold > load-use > flush
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_ctrl  <= BUB;
      ex_rd    <= '0;
      mem_ctrl <= BUB;
      mem_rd   <= '0;
      wb_ctrl  <= BUB;
      wb_rd    <= '0;
    end else begin
      wb_ctrl <= mem_ctrl;
      wb_rd   <= mem_rd;
      if (mul_hold) begin
        mem_ctrl <= BUB;
        mem_rd   <= '0;
      end else begin
        mem_ctrl <= ex_ctrl;
        mem_rd   <= ex_rd;
        if (load_use || bus.flush_i || !dec_valid) begin
          ex_ctrl <= BUB;
          ex_rd   <= '0;
        end else begin
          ex_ctrl <= dec_ctrl;
          ex_rd   <= rd;
        end
      end
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  // sticky flag for undecoded non-zero words in ID
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      illegal_q <= 1'b0;
    end else if (!dec_valid && (bus.instr_i != '0)
                 && !stall && !bus.flush_i) begin
      illegal_q <= 1'b1;
    end
  end

  assign bus.illegal_o = illegal_q;
`else
  assign bus.illegal_o = 1'b0;
`endif

  assign bus.ex_ctrl_o  = ex_ctrl;
  assign bus.ex_rd_o    = ex_rd;
  assign bus.mem_ctrl_o = mem_ctrl;
  assign bus.wb_ctrl_o  = wb_ctrl;
  assign bus.wb_rd_o    = wb_rd;
  assign bus.stall_o    = stall;
  assign bus.mul_busy_o = (state == S_BUSY);

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Bench for ctrl_pipe_unit: directed scenarios plus
// random stream against a stage-level reference model.
`timescale 1ns/1ps
module tb_ctrl_pipe_unit;

  localparam int MULC = 4;

  typedef struct packed {
    logic       jalr;
    logic       jal;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       is_mul;
  } bun_t;

  localparam logic [31:0] ADD   = 32'h003100B3;
  localparam logic [31:0] LW5   = 32'h0000A283;
  localparam logic [31:0] ADD6  = 32'h00228333;
  localparam logic [31:0] LW0   = 32'h0000A003;
  localparam logic [31:0] ADD60 = 32'h00200333;
  localparam logic [31:0] MUL   = 32'h022083B3;
  localparam logic [31:0] BEQ   = 32'h00208063;
  localparam logic [31:0] JAL   = 32'h0000006F;
  localparam logic [31:0] ILL   = 32'h0000007F;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ctrl_pipe_unit_if #(
    .ALUOP_W    (2),
    .REG_ADDR_W (5)
  ) bus ();

  ctrl_pipe_unit #(
    .MUL_CYCLES (MULC),
    .ALUOP_W    (2),
    .REG_ADDR_W (5)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, got, exp, $time);
    end
  endtask

  function automatic bun_t ref_dec(input logic [31:0] i);
    bun_t b;
    b = '0;
    case (i[6:0])
      7'h33: begin
        b.reg_write = 1'b1;
        b.is_mul    = (i[31:25] == 7'h01);
      end
      7'h13: begin
        b.alu_src   = 1'b1;
        b.reg_write = 1'b1;
      end
      7'h03: begin
        b.mem_read   = 1'b1;
        b.mem_to_reg = 1'b1;
        b.alu_src    = 1'b1;
        b.reg_write  = 1'b1;
      end
      7'h23: begin
        b.mem_write = 1'b1;
        b.alu_src   = 1'b1;
      end
      7'h63: b.branch = 1'b1;
      7'h6F: begin
        b.jal       = 1'b1;
        b.branch    = 1'b1;
        b.reg_write = 1'b1;
      end
      7'h67: begin
        b.jalr      = 1'b1;
        b.branch    = 1'b1;
        b.reg_write = 1'b1;
      end
      default: ;
    endcase
    if (b != '0) b.alu_op = i[4:3];
    return b;
  endfunction

  // {rs1 used, rs2 used}
  function automatic logic [1:0] ref_use(input logic [31:0] i);
    logic [6:0] op;
    op = i[6:0];
    ref_use[1] = (ref_dec(i) != '0) && (op != 7'h6F);
    ref_use[0] = (op == 7'h33) || (op == 7'h23)
              || (op == 7'h63);
  endfunction

  // Model: each stage holds one bundle; a MUL stays in
  // EX for MULC cycles counted by its age there.
  bun_t       m_ex, m_mem, m_wb;
  logic [4:0] m_ex_rd, m_mem_rd, m_wb_rd;
  int         m_age;
  logic       m_ill;

  bun_t       e_dec;
  logic [1:0] e_u;
  logic       e_hold, e_busy, e_lu, e_stall;

  always_comb begin
    e_dec  = ref_dec(bus.instr_i);
    e_u    = ref_use(bus.instr_i);
    e_hold = m_ex.is_mul && (MULC > 1) && (m_age < MULC);
    e_busy = m_ex.is_mul && (MULC > 1) && (m_age >= 2);
    e_lu   = m_ex.mem_read && (m_ex_rd != 5'd0)
          && ((e_u[1] && (bus.instr_i[19:15] == m_ex_rd))
           || (e_u[0] && (bus.instr_i[24:20] == m_ex_rd)));
    e_stall = e_hold || e_lu;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_ex     <= '0;
      m_mem    <= '0;
      m_wb     <= '0;
      m_ex_rd  <= '0;
      m_mem_rd <= '0;
      m_wb_rd  <= '0;
      m_age    <= 0;
      m_ill    <= 1'b0;
    end else begin
      m_wb    <= m_mem;
      m_wb_rd <= m_mem_rd;
      if (e_hold) begin
        m_mem    <= '0;
        m_mem_rd <= '0;
        m_age    <= m_age + 1;
      end else begin
        m_mem    <= m_ex;
        m_mem_rd <= m_ex_rd;
        m_age    <= 1;
        if (e_lu || bus.flush_i || (e_dec == '0)) begin
          m_ex    <= '0;
          m_ex_rd <= '0;
        end else begin
          m_ex    <= e_dec;
          m_ex_rd <= bus.instr_i[11:7];
        end
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      if ((e_dec == '0) && (bus.instr_i != 32'd0)
          && !e_stall && !bus.flush_i)
        m_ill <= 1'b1;
`endif
    end
  end

  // compare DUT against model every cycle
  always @(negedge clk) begin
    #2;
    chk("ex_ctrl",  32'(bus.ex_ctrl_o),  32'(m_ex));
    chk("ex_rd",    32'(bus.ex_rd_o),    32'(m_ex_rd));
    chk("mem_ctrl", 32'(bus.mem_ctrl_o), 32'(m_mem));
    chk("wb_ctrl",  32'(bus.wb_ctrl_o),  32'(m_wb));
    chk("wb_rd",    32'(bus.wb_rd_o),    32'(m_wb_rd));
    chk("stall",    32'(bus.stall_o),    32'(e_stall));
    chk("mul_busy", 32'(bus.mul_busy_o), 32'(e_busy));
    chk("illegal",  32'(bus.illegal_o),  32'(m_ill));
  end

  task automatic step(input logic [31:0] i,
                      input logic f,
                      input logic r);
    @(negedge clk);
    bus.instr_i = i;
    bus.flush_i = f;
    rst         = r;
    #3;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [6:0] op;
    logic [6:0] f7;
    logic [4:0] rd, r1, r2;
    logic [2:0] f3;
    int k;
    if ($urandom_range(0, 15) == 0) return 32'd0;
    k  = $urandom_range(0, 10);
    rd = 5'($urandom_range(0, 3));
    r1 = 5'($urandom_range(0, 3));
    r2 = 5'($urandom_range(0, 3));
    f3 = 3'($urandom);
    f7 = 7'($urandom);
    case (k)
      0, 1, 2: begin
        op = 7'h33;
        f7 = ($urandom_range(0, 2) == 0) ? 7'h01 : 7'h00;
      end
      3:       op = 7'h13;
      4, 5:    op = 7'h03;
      6:       op = 7'h23;
      7:       op = 7'h63;
      8:       op = 7'h6F;
      9:       op = 7'h67;
      default: op = ($urandom_range(0, 1) != 0) ? 7'h7F : 7'h0B;
    endcase
    return {f7, r2, r1, f3, rd, op};
  endfunction

  initial begin
    logic [31:0] cur;
    int n_st, n_bz, n_mb;
    bus.instr_i = '0;
    bus.flush_i = 1'b0;

    chk("pin_add",  32'(ref_dec(ADD)), 32'h022);
    chk("pin_lw",   32'(ref_dec(LW5)), 32'h0C6);
    chk("pin_mul",  32'(ref_dec(MUL)), 32'h023);
    chk("pin_jal",  32'(ref_dec(JAL)), 32'h312);
    chk("pin_ill",  32'(ref_dec(ILL)), 32'h000);
    chk("pin_use",  32'(ref_use(JAL)), 32'h0);

    step(32'd0, 1'b0, 1'b1);
    step(32'd0, 1'b0, 1'b1);
    chk("rst_ex",    32'(bus.ex_ctrl_o),  32'h0);
    chk("rst_wb",    32'(bus.wb_ctrl_o),  32'h0);
    chk("rst_stall", 32'(bus.stall_o),    32'h0);
    chk("rst_busy",  32'(bus.mul_busy_o), 32'h0);
    chk("rst_ill",   32'(bus.illegal_o),  32'h0);

    step(ADD, 1'b0, 1'b0);
    step(32'd0, 1'b0, 1'b0);
    chk("add_ex",    32'(bus.ex_ctrl_o), 32'h022);
    chk("add_ex_rd", 32'(bus.ex_rd_o),   32'd1);
    step(32'd0, 1'b0, 1'b0);
    chk("add_mem",   32'(bus.mem_ctrl_o), 32'h022);
    step(32'd0, 1'b0, 1'b0);
    chk("add_wb",    32'(bus.wb_ctrl_o), 32'h022);
    chk("add_wb_rd", 32'(bus.wb_rd_o),   32'd1);
    chk("add_stall", 32'(bus.stall_o),   32'h0);

    step(LW5, 1'b0, 1'b0);
    step(ADD6, 1'b0, 1'b0);
    chk("lu_stall", 32'(bus.stall_o), 32'h1);
    step(ADD6, 1'b0, 1'b0);
    chk("lu_bubble", 32'(bus.ex_ctrl_o), 32'h0);
    chk("lu_stall1", 32'(bus.stall_o),   32'h0);
    step(32'd0, 1'b0, 1'b0);
    chk("lu_add_ex", 32'(bus.ex_ctrl_o), 32'h022);
    chk("lu_add_rd", 32'(bus.ex_rd_o),   32'd6);

    step(LW0, 1'b0, 1'b0);
    step(ADD60, 1'b0, 1'b0);
    chk("x0_stall", 32'(bus.stall_o), 32'h0);
    step(32'd0, 1'b0, 1'b0);
    chk("x0_add_ex", 32'(bus.ex_ctrl_o), 32'h022);

    step(BEQ, 1'b1, 1'b0);
    step(32'd0, 1'b0, 1'b0);
    chk("flush_ex", 32'(bus.ex_ctrl_o), 32'h0);

    step(32'd0, 1'b0, 1'b0);
    step(MUL, 1'b0, 1'b0);
    n_st = 0;
    n_bz = 0;
    n_mb = 0;
    for (int k = 1; k <= 6; k++) begin
      if (k == 2) step(BEQ, 1'b1, 1'b0);
      else        step(32'd0, 1'b0, 1'b0);
      if (bus.stall_o)    n_st++;
      if (bus.mul_busy_o) n_bz++;
      if (k >= 2 && k <= 4 && bus.mem_ctrl_o == '0) n_mb++;
      if (k == 3)
        chk("mul_hold_ex", 32'(bus.ex_ctrl_o), 32'h023);
      if (k == 5)
        chk("mul_mem", 32'(bus.mem_ctrl_o), 32'h023);
    end
    chk("mul_stalls",  32'(n_st), 32'd3);
    chk("mul_busy",    32'(n_bz), 32'd3);
    chk("mul_bubbles", 32'(n_mb), 32'd3);

    step(ILL, 1'b0, 1'b0);
    step(32'd0, 1'b0, 1'b0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("ill_set", 32'(bus.illegal_o), 32'h1);
    step(ADD, 1'b0, 1'b0);
    step(32'd0, 1'b0, 1'b0);
    chk("ill_sticky", 32'(bus.illegal_o), 32'h1);
    step(32'd0, 1'b0, 1'b1);
    step(32'd0, 1'b0, 1'b0);
    chk("ill_clr", 32'(bus.illegal_o), 32'h0);
`else
    chk("ill_off", 32'(bus.illegal_o), 32'h0);
    step(32'd0, 1'b0, 1'b0);
    chk("ill_off1", 32'(bus.illegal_o), 32'h0);
`endif

    cur = 32'd0;
    for (int n = 0; n < 3000; n++) begin
      logic r, f;
      if (!bus.stall_o) cur = rnd_instr();
      r = ($urandom_range(0, 199) == 0);
      f = ($urandom_range(0, 7) == 0);
      step(cur, f, r);
    end
    step(32'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
